// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate generator pipeline.
// Holds the im_op encoding and the legal XLEN values.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_ISH  = 3'd2,
        IMM_S    = 3'd3,
        IMM_B    = 3'd4,
        IMM_U    = 3'd5,
        IMM_J    = 3'd6,
        IMM_CSR  = 3'd7
    } im_op_e;

    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

    function automatic bit xlen_legal(input int x);
        return (x == XLEN_RV32) || (x == XLEN_RV64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RISC-V immediate decoder (ins = instr[31:7]).
// IMM_GEN_CSR_EN enables the CSR-uimm format; otherwise op 7 flags err.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      im_op,
    input  logic [24:0]     ins,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    localparam bit W64 = (XLEN == XLEN_RV64);

    logic [31:0] v;
    logic        sx;

    always_comb begin
        v   = '0;
        sx  = 1'b0;
        err = 1'b0;
        unique case (im_op_e'(im_op))
            IMM_NONE: v = '0;
            IMM_I: begin
                v  = {20'd0, ins[24:13]};
                v  = {{20{ins[24]}}, ins[24:13]};
                sx = 1'b1;
            end
            IMM_ISH: begin
                if (W64) v = {26'd0, ins[18:13]};
                else     v = {27'd0, ins[17:13]};
            end
            IMM_S: begin
                v  = {{20{ins[24]}}, ins[24:18], ins[4:0]};
                sx = 1'b1;
            end
            IMM_B: begin
                v  = {{19{ins[24]}}, ins[24], ins[0],
                      ins[23:18], ins[4:1], 1'b0};
                sx = 1'b1;
            end
            IMM_U: begin
                v  = {ins[24:5], 12'd0};
                sx = 1'b1;
            end
            IMM_J: begin
                v  = {{11{ins[24]}}, ins[24], ins[12:5],
                      ins[13], ins[23:14], 1'b0};
                sx = 1'b1;
            end
            IMM_CSR: begin
`ifdef IMM_GEN_CSR_EN
                v   = {27'd0, ins[12:8]};
`else
                err = 1'b1;
`endif
            end
            default: v = '0;
        endcase
    end

    // Every 32-bit form is already sign-correct; widen per format.
    always_comb begin
        if (sx) imm = XLEN'($signed(v));
        else    imm = XLEN'(v);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry output FIFO (valid/ready both sides).
// Define IMM_GEN_CSR_EN to decode im_op 7 as a CSR zero-extended uimm.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   im_op,
    input  logic [24:0]                  ins,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              imm,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_err,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic             err_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [XLEN-1:0] d_imm;
    logic            d_err;
    logic            push;
    logic            pop;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .im_op (im_op),
        .ins   (ins),
        .imm   (d_imm),
        .err   (d_err)
    );

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wr_ptr] <= d_imm;
            tag_mem[wr_ptr] <= in_tag;
            err_mem[wr_ptr] <= d_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty buffer presents zeros, so reset clears the outputs at once.
    always_comb begin
        imm     = '0;
        out_tag = '0;
        out_err = 1'b0;
        if (out_valid) begin
            imm     = imm_mem[rd_ptr];
            out_tag = tag_mem[rd_ptr];
            out_err = err_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV32/DEPTH=2 and an RV64/DEPTH=4
// instance share stimulus; a reference decoder works on full instructions.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_CSR_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  im_op;
    logic [24:0] ins;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic [1:0]  count32;

    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [4:0]  tag64;
    logic [2:0]  count64;

    exp_t sb32[$];
    exp_t sb64[$];
    int   n_cmp;
    int   n_fail;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready32),
        .im_op(im_op), .ins(ins), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .out_tag(tag32), .out_err(err32),
        .count(count32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .DEPTH(4)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64),
        .im_op(im_op), .ins(ins), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .out_tag(tag64), .out_err(err64),
        .count(count64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic [2:0] op, input logic [24:0] s,
                                input logic [4:0] t, input bit w64);
        exp_t e;
        logic [31:0] i;
        i = {s, 7'h13};
        e.imm = '0;
        e.tag = t;
        e.err = 1'b0;
        case (op)
            3'd1: e.imm = {{52{i[31]}}, i[31:20]};
            3'd2: e.imm = w64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            3'd3: e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd4: e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd5: e.imm = {{32{i[31]}}, i[31:12], 12'd0};
            3'd6: e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd7: begin
                if (CSR_EN) e.imm = {59'd0, i[19:15]};
                else        e.err = 1'b1;
            end
            default: e.imm = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst_n) begin
            if (out_valid32 && out_ready) begin
                n_cmp++;
                if (sb32.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb32_extra: got tag %0d, required none", tag32);
                end else begin
                    e = sb32.pop_front();
                    if (imm32 !== e.imm[31:0] || tag32 !== e.tag || err32 !== e.err) begin
                        n_fail++;
                        $display("FAIL sb32: got imm=%h tag=%0d err=%b, required imm=%h tag=%0d err=%b",
                                 imm32, tag32, err32, e.imm[31:0], e.tag, e.err);
                    end
                end
            end
            if (in_valid && in_ready32) sb32.push_back(mk(im_op, ins, in_tag, 1'b0));
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (rst_n) begin
            if (out_valid64 && out_ready) begin
                n_cmp++;
                if (sb64.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb64_extra: got tag %0d, required none", tag64);
                end else begin
                    e = sb64.pop_front();
                    if (imm64 !== e.imm || tag64 !== e.tag || err64 !== e.err) begin
                        n_fail++;
                        $display("FAIL sb64: got imm=%h tag=%0d err=%b, required imm=%h tag=%0d err=%b",
                                 imm64, tag64, err64, e.imm, e.tag, e.err);
                    end
                end
            end
            if (in_valid && in_ready64) sb64.push_back(mk(im_op, ins, in_tag, 1'b1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((out_valid32 || out_valid64) && k < 12) begin
            tick();
            k++;
        end
        n_cmp++;
        if (out_valid32 || out_valid64 || sb32.size() != 0 || sb64.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got sb32=%0d sb64=%0d v32=%b v64=%b, required all empty",
                     sb32.size(), sb64.size(), out_valid32, out_valid64);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({count32, out_valid32, imm32, tag32, err32, in_ready32} !==
            {2'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset32: got cnt=%0d v=%b imm=%h tag=%0d err=%b rdy=%b, required 0 0 0 0 0 1",
                     count32, out_valid32, imm32, tag32, err32, in_ready32);
        end
        n_cmp++;
        if ({count64, out_valid64, imm64, tag64, err64, in_ready64} !==
            {3'd0, 1'b0, 64'd0, 5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset64: got cnt=%0d v=%b imm=%h tag=%0d err=%b rdy=%b, required 0 0 0 0 0 1",
                     count64, out_valid64, imm64, tag64, err64, in_ready64);
        end
    endtask

    task automatic test_vectors32();
        logic [2:0]  op  [8] = '{3'd1, 3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd0, 3'd7};
        logic [31:0] ins_t [8] = '{32'hFFF00013, 32'hFE000EE3, 32'h0080006F,
                                   32'hFE000C23, 32'h12345037, 32'h03F00013,
                                   32'hDEADBEEF, 32'h000F8073};
        logic [31:0] ex  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008,
                                 32'hFFFFFFF8, 32'h12345000, 32'h0000001F,
                                 32'h00000000, CSR_EN ? 32'd31 : 32'd0};
        logic        exe [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !CSR_EN};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            im_op    = op[i];
            ins      = ins_t[i][31:7];
            in_tag   = 5'(i + 4);
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid32 !== 1'b1 || imm32 !== ex[i] || err32 !== exe[i]) begin
                n_fail++;
                $display("FAIL vec32[%0d]: got v=%b imm=%h err=%b, required v=1 imm=%h err=%b",
                         i, out_valid32, imm32, err32, ex[i], exe[i]);
            end
            tick();
        end
    endtask

    task automatic test_vectors64();
        logic [2:0]  op  [3] = '{3'd5, 3'd2, 3'd1};
        logic [31:0] ins_t [3] = '{32'h80000037, 32'h03F00013, 32'h80000013};
        logic [63:0] ex  [3] = '{64'hFFFFFFFF80000000, 64'd63, 64'hFFFFFFFFFFFFF800};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            im_op    = op[i];
            ins      = ins_t[i][31:7];
            in_tag   = 5'(i + 20);
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid64 !== 1'b1 || imm64 !== ex[i] || err64 !== 1'b0) begin
                n_fail++;
                $display("FAIL vec64[%0d]: got v=%b imm=%h err=%b, required v=1 imm=%h err=0",
                         i, out_valid64, imm64, err64, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        im_op     = 3'd1;
        ins       = 25'h1ABCDEF;
        for (int t = 1; t <= 3; t++) begin
            in_valid = 1'b1;
            in_tag   = 5'(t);
            if (t < 3) tick();
        end
        n_cmp++;
        if (in_ready32 !== 1'b0 || count32 !== 2'd2) begin
            n_fail++;
            $display("FAIL full32: got rdy=%b cnt=%0d, required rdy=0 cnt=2", in_ready32, count32);
        end
        tick();
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count32 !== 2'd2 || tag32 !== 5'd1 || out_valid32 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold32: got cnt=%0d tag=%0d v=%b, required cnt=2 tag=1 v=1",
                     count32, tag32, out_valid32);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (tag32 !== 5'd2 || count32 !== 2'd1) begin
            n_fail++;
            $display("FAIL order32: got tag=%0d cnt=%0d, required tag=2 cnt=1", tag32, count32);
        end
        tick();
        n_cmp++;
        if (out_valid32 !== 1'b0) begin
            n_fail++;
            $display("FAIL empty32: got v=%b, required 0", out_valid32);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            im_op     = 3'($urandom_range(0, 7));
            ins       = 25'($urandom);
            in_tag    = 5'($urandom);
            tick();
            n_cmp++;
            if (count32 !== 2'(sb32.size()) || in_ready32 !== (sb32.size() < 2) ||
                count64 !== 3'(sb64.size())) begin
                n_fail++;
                $display("FAIL occ[%0d]: got c32=%0d r32=%b c64=%0d, required c32=%0d c64=%0d",
                         c, count32, in_ready32, count64, sb32.size(), sb64.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        im_op     = 3'd5;
        ins       = 25'h0F0F0F0;
        in_tag    = 5'd9;
        tick();
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count32 !== 2'd2) begin
            n_fail++;
            $display("FAIL prefill32: got cnt=%0d, required 2", count32);
        end
        #2 rst_n = 1'b0;
        #1;
        sb32.delete();
        sb64.delete();
        n_cmp++;
        if (count32 !== 2'd0 || out_valid32 !== 1'b0 || imm32 !== 32'd0 ||
            count64 !== 3'd0 || out_valid64 !== 1'b0) begin
            n_fail++;
            $display("FAIL arst: got c32=%0d v32=%b imm32=%h c64=%0d v64=%b, required all 0",
                     count32, out_valid32, imm32, count64, out_valid64);
        end
        #3 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
            n_fail++;
            $display("FAIL release: got rdy=%b v=%b, required rdy=1 v=0", in_ready32, out_valid32);
        end
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        im_op     = 3'd0;
        ins       = '0;
        in_tag    = '0;
        tick();
        test_reset();
        #3 rst_n = 1'b1;
        tick();
        test_vectors32();
        drain();
        test_vectors64();
        drain();
        test_backpressure();
        drain();
        test_back_to_back();
        drain();
        test_reset_mid();
        test_back_to_back();
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate width; legal values 32 or 64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried with each request.
REQ-003 Parameter DEPTH, default 2, output buffer entries; legal values 2 to 8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 im_op  input  3  format: 0 none, 1 I, 2 I-shift, 3 S, 4 B, 5 U, 6 J, 7 CSR-uimm.
REQ-009 ins  input  25  instruction bits [31:7]; ins[k] is instruction bit k+7.
REQ-010 in_tag  input  TAG_W  sideband, returned unmodified.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 imm  output  XLEN  generated immediate.
REQ-014 out_tag  output  TAG_W  tag of the current result.
REQ-015 out_err  output  1  current result came from an illegal im_op.
REQ-016 count  output  clog2(DEPTH+1)  buffer occupancy.

Function
REQ-017 Decode, sext to XLEN: I = ins[24:13]; S = {ins[24:18],ins[4:0]}; B = {ins[24],ins[0],ins[23:18],ins[4:1],1'b0}; J = {ins[24],ins[12:5],ins[13],ins[23:14],1'b0}; U = {ins[24:5],12'b0}.
REQ-018 I-shift zero-extends ins[17:13] when XLEN=32, or ins[18:13] when XLEN=64.
REQ-019 im_op 0 yields imm 0 and out_err 0.
REQ-020 Decode is combinational into the buffer write port; the buffer stores {imm, tag, err}.
REQ-021 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-022 in_ready = (count < DEPTH); it does not depend on out_ready in the same cycle.
REQ-023 out_valid = (count != 0); imm, out_tag and out_err show the oldest entry.
REQ-024 Latency is 1 cycle: a request pushed into an empty buffer is at the output on the next edge.
REQ-025 Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and order is preserved.
REQ-026 When full, in_ready=0, so no push occurs even if a pop occurs in that cycle.
REQ-027 Output fields hold stable while out_valid && !out_ready.
REQ-028 Read and write pointers wrap modulo DEPTH.

Reset
REQ-029 On rst_n low, asynchronously: count=0, pointers=0, out_valid=0, imm=0, out_tag=0, out_err=0.
REQ-030 Reset asserted mid-operation discards all buffered entries; in_ready=1 on the first cycle after release.

Configuration
REQ-031 With IMM_GEN_CSR_EN defined, im_op 7 zero-extends ins[12:8] with out_err=0.
REQ-032 Without IMM_GEN_CSR_EN, im_op 7 yields imm 0 with out_err=1, and the entry is still pushed.

Structure
REQ-033 Package imm_gen_pkg holds the im_op enum (IMM_NONE..IMM_CSR) and the XLEN legality constants.
REQ-034 Decode sits in one combinational sub-module imm_decode (im_op, ins, XLEN param -> imm, err).
REQ-035 The top level contains only the circular buffer, pointers and count.

Verification
REQ-036 XLEN=32, op1, ins[24:13]=12'hFFF, pushed into an empty buffer -> next cycle out_valid=1, imm=32'hFFFFFFFF.
REQ-037 Op4, instruction 32'hFE000EE3 (beq offset -4) -> imm=32'hFFFFFFFC; op6, instruction 32'h0080006F -> imm=32'h00000008.
REQ-038 XLEN=64, op5, ins[24:5]=20'h80000 -> imm=64'hFFFFFFFF80000000; op2, ins[18:13]=6'h3F -> imm=63.
REQ-039 DEPTH=2, out_ready=0, push tags 1, 2, 3 -> tag 3 refused (in_ready=0), count=2; then out_ready=1 -> tags 1 then 2 appear in order.
REQ-040 Op7 with ins[12:8]=5'h1F -> imm=31, err=0 with the macro defined; imm=0, err=1 without it.
REQ-041 rst_n pulsed low while count=2 -> count=0 and out_valid=0 immediately, in_ready=1 after release.
